// File: rtl/lsu.sv
// Load/store unit in front of a word-only data memory: alignment/funct3 checks,
// load extraction with extension, sub-word stores via read-modify-write.
// Optional build macro LSU_MISALIGN_TRAP_EN: misaligned halfword/word requests
// return an error instead of being forced to natural alignment.
module lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, DONE} state_t;

  state_t      state, state_nxt;
  logic        store_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic        err_q;
  logic signed [31:0] rdata_q;
  logic [31:0] wdata_q;
  logic [31:0] merged_q;
  logic        req_err;

  function automatic logic illegal_op(input logic st, input logic [2:0] f3);
    if (st) return f3[2] || (f3[1:0] == 2'b11);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11);
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b01:   return lo[0];
      2'b10:   return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Natural alignment; only matters when misalignment is not trapped.
  function automatic logic [31:0] align_addr(input logic [2:0] f3, input logic [31:0] a);
    case (f3[1:0])
      2'b01:   return {a[31:1], 1'b0};
      2'b10:   return {a[31:2], 2'b00};
      default: return a;
    endcase
  endfunction

  function automatic logic signed [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                                     input logic [31:0] word);
    logic [31:0]        shifted;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    shifted = word >> {off, 3'b000};
    b_s = shifted[7:0];
    h_s = shifted[15:0];
    case (f3)
      3'b000:  return 32'(b_s);
      3'b001:  return 32'(h_s);
      3'b100:  return {24'd0, shifted[7:0]};
      3'b101:  return {16'd0, shifted[15:0]};
      default: return shifted;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] old, input logic [31:0] wd);
    logic [31:0] mask;
    mask = (f3[0] ? 32'h0000_FFFF : 32'h0000_00FF) << {off, 3'b000};
    return (old & ~mask) | ((wd << {off, 3'b000}) & mask);
  endfunction

`ifdef LSU_MISALIGN_TRAP_EN
  assign req_err = illegal_op(req_store, req_funct3) || misaligned(req_funct3, req_addr[1:0]);
`else
  assign req_err = illegal_op(req_store, req_funct3);
`endif

  // Control and response registers: cleared by reset because they are visible on ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      store_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (req_valid) begin
          store_q  <= req_store;
          funct3_q <= req_funct3;
          addr_q   <= align_addr(req_funct3, req_addr);
          err_q    <= req_err;
          rdata_q  <= '0;
        end
        ACCESS: if (!store_q) rdata_q <= load_extend(funct3_q, addr_q[1:0], mem_rd);
        default: ;
      endcase
    end
  end

  // Store data path: only consumed while mem_we is high, so no reset needed.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) wdata_q <= req_wdata;
    if (state == ACCESS) merged_q <= store_merge(funct3_q, addr_q[1:0], mem_rd, wdata_q);
  end

  always_comb begin
    state_nxt  = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_we     = 1'b0;
    mem_wd     = 32'd0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_err ? DONE : ACCESS;
      end
      ACCESS: begin
        // Legal stores are 000/001/010, so funct3[1] alone marks SW.
        if (store_q && funct3_q[1]) begin
          mem_we    = 1'b1;
          mem_wd    = wdata_q;
          state_nxt = DONE;
        end else if (store_q) begin
          state_nxt = WRITE;
        end else begin
          state_nxt = DONE;
        end
      end
      WRITE: begin
        mem_we    = 1'b1;
        mem_wd    = merged_q;
        state_nxt = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Reset must cancel an in-flight write and response in the same cycle.
    if (rst) begin
      mem_we     = 1'b0;
      mem_wd     = 32'd0;
      resp_valid = 1'b0;
    end
  end

  assign mem_addr   = {addr_q[31:2], 2'b00};
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: word-array memory, request-level reference model,
// and one per-cycle compare process.
`timescale 1ns/1ps
module tb_lsu;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:63];
  logic [31:0] model_mem [0:63];
  logic        bd_we = 1'b0;
  logic [5:0]  bd_idx = 6'd0;
  logic [31:0] bd_val = 32'd0;

  int errors = 0;
  int checks = 0;

  // Expectations for the current transaction, written by the driver
  int          start_id = 0;
  logic        e_err;
  logic [31:0] e_rd, e_wword, e_waddr, lit_val;
  int          e_lat, e_we, e_abort;
  bit          lit_en;
  bit          rst_chk = 1'b0;
  bit          idle_chk = 1'b0;
  int          memchk_id = 0;
  logic [5:0]  mc_idx;
  logic [31:0] mc_val;

  // Compare-process state
  int done_id = 0;
  int seen_id = 0;
  int memchk_seen = 0;
  int cyc = 0;
  bit active = 1'b0;

  lsu dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  always #5 clk = ~clk;

  assign mem_rd = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:2]] <= mem_wd;
    else if (bd_we) mem[bd_idx] <= bd_val;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Request-level reference: what the core must see and what memory must receive.
  task automatic model(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic err, output logic [31:0] rd,
                       output logic [31:0] ww, output int lat, output int wc);
    int sz, off;
    logic ill, mis;
    logic [31:0] w, v, mask;
    sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    ill = st ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
    off = int'(a[1:0]);
    mis = (off % sz) != 0;
`ifdef LSU_MISALIGN_TRAP_EN
    err = ill || mis;
`else
    err = ill;
    off = off - (off % sz);
`endif
    w = model_mem[a[7:2]];
    rd = 32'd0; ww = w; wc = 0;
    if (err) begin
      lat = 1;
    end else if (!st) begin
      lat = 2;
      v = w >> (8 * off);
      if (sz == 1)      rd = f3[2] ? {24'd0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      else if (sz == 2) rd = f3[2] ? {16'd0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      else              rd = w;
    end else if (sz == 4) begin
      lat = 2; wc = 1; ww = wd;
    end else begin
      lat = 3; wc = 2;
      mask = ((sz == 1) ? 32'hFF : 32'hFFFF) << (8 * off);
      ww = (w & ~mask) | ((wd << (8 * off)) & mask);
    end
  endtask

  always @(negedge clk) begin
    if (rst_chk) begin
      chk1("rst_req_ready", req_ready, 1'b1);
      chk1("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk1("rst_resp_err", resp_err, 1'b0);
      chk1("rst_mem_we", mem_we, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'd0);
      chk("rst_mem_wd", mem_wd, 32'd0);
    end
    if (start_id != seen_id) begin
      seen_id = start_id;
      active  = 1'b1;
      cyc     = 0;
    end
    if (active) begin
      cyc++;
      if (e_abort != 0 && cyc >= e_abort) begin
        chk1("abort_mem_we", mem_we, 1'b0);
        chk1("abort_resp_valid", resp_valid, 1'b0);
        if (cyc > e_abort) begin
          chk1("abort_req_ready", req_ready, 1'b1);
          active  = 1'b0;
          done_id = seen_id;
        end
      end else begin
        chk1("busy_req_ready", req_ready, 1'b0);
        chk1("resp_valid", resp_valid, cyc == e_lat);
        chk1("mem_we", mem_we, cyc == e_we);
        if (cyc == e_we) begin
          chk("mem_addr", mem_addr, e_waddr);
          chk("mem_wd", mem_wd, e_wword);
        end
        if (cyc >= e_lat) begin
          chk("resp_rdata", resp_rdata, e_rd);
          chk1("resp_err", resp_err, e_err);
          if (lit_en) chk("lit_rdata", resp_rdata, lit_val);
          active  = 1'b0;
          done_id = seen_id;
        end
      end
    end else if (idle_chk) begin
      chk1("idle_req_ready", req_ready, 1'b1);
      chk1("idle_resp_valid", resp_valid, 1'b0);
      chk1("idle_mem_we", mem_we, 1'b0);
      chk("idle_mem_wd", mem_wd, 32'd0);
    end
    if (memchk_id != memchk_seen) begin
      memchk_seen = memchk_id;
      chk("mem_word", mem[mc_idx], mc_val);
    end
  end

  task automatic backdoor(input logic [5:0] idx, input logic [31:0] val);
    @(posedge clk); #1;
    bd_we = 1'b1; bd_idx = idx; bd_val = val;
    model_mem[idx] = val;
    @(posedge clk); #1;
    bd_we = 1'b0;
  endtask

  task automatic memchk(input logic [5:0] idx, input logic [31:0] val);
    @(posedge clk); #1;
    mc_idx = idx; mc_val = val;
    memchk_id++;
    @(negedge clk);
    @(posedge clk);
  endtask

  task automatic txn(input logic st, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input bit le, input logic [31:0] lv, input int abort);
    logic err;
    logic [31:0] rd, ww;
    int lat, wc;
    model(st, f3, a, wd, err, rd, ww, lat, wc);
    if (wc != 0 && abort == 0) model_mem[a[7:2]] = ww;
    @(negedge clk);
    e_err = err; e_rd = rd; e_wword = ww; e_waddr = {a[31:2], 2'b00};
    e_lat = lat; e_we = wc; e_abort = abort; lit_en = le; lit_val = lv;
    req_valid = 1'b1; req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    start_id++;
    if (abort != 0) begin
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
    end
    for (int k = 0; k < 20; k++) begin
      if (done_id == start_id) break;
      @(negedge clk);
    end
    if (done_id != start_id) begin
      $display("FAIL txn_timeout: transaction %0d did not complete, expected within 20 cycles", start_id);
      $fatal(1, "transaction timeout");
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_chk = 1'b1;
    @(posedge clk);
    #1 rst_chk = 1'b0; rst = 1'b0; idle_chk = 1'b1;

    backdoor(6'd16, 32'h8765_43A1);
    backdoor(6'd4, 32'd0);
    backdoor(6'd5, 32'd0);

    txn(1'b0, 3'b000, 32'h40, 32'd0, 1'b1, 32'hFFFF_FFA1, 0);
    txn(1'b0, 3'b100, 32'h43, 32'd0, 1'b1, 32'h0000_0087, 0);
    txn(1'b0, 3'b001, 32'h42, 32'd0, 1'b1, 32'hFFFF_8765, 0);
    txn(1'b0, 3'b010, 32'h40, 32'd0, 1'b1, 32'h8765_43A1, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    txn(1'b0, 3'b010, 32'h42, 32'd0, 1'b1, 32'd0, 0);
`else
    txn(1'b0, 3'b010, 32'h42, 32'd0, 1'b1, 32'h8765_43A1, 0);
`endif
    txn(1'b0, 3'b011, 32'h40, 32'd0, 1'b1, 32'd0, 0);
    txn(1'b0, 3'b101, 32'h41, 32'd0, 1'b0, 32'd0, 0);

    backdoor(6'd16, 32'h1122_3344);
    txn(1'b1, 3'b000, 32'h41, 32'hAAAA_AA5C, 1'b1, 32'd0, 0);
    memchk(6'd16, 32'h1122_5C44);
    txn(1'b0, 3'b010, 32'h40, 32'd0, 1'b1, 32'h1122_5C44, 0);
    txn(1'b0, 3'b101, 32'h42, 32'd0, 1'b1, 32'h0000_1122, 0);
    txn(1'b0, 3'b000, 32'h43, 32'd0, 1'b1, 32'h0000_0011, 0);
    txn(1'b0, 3'b001, 32'h40, 32'd0, 1'b1, 32'h0000_5C44, 0);

    txn(1'b1, 3'b001, 32'h12, 32'h1234_BEEF, 1'b1, 32'd0, 0);
    memchk(6'd4, 32'hBEEF_0000);
    txn(1'b1, 3'b010, 32'h14, 32'hDEAD_BEEF, 1'b1, 32'd0, 0);
    memchk(6'd5, 32'hDEAD_BEEF);
    txn(1'b0, 3'b010, 32'h14, 32'd0, 1'b1, 32'hDEAD_BEEF, 0);

    txn(1'b1, 3'b100, 32'h40, 32'h0000_00FF, 1'b1, 32'd0, 0);
    txn(1'b1, 3'b011, 32'h40, 32'hFFFF_FFFF, 1'b1, 32'd0, 0);
    memchk(6'd16, 32'h1122_5C44);
    txn(1'b1, 3'b001, 32'h41, 32'h0000_9999, 1'b0, 32'd0, 0);
    memchk(6'd16, model_mem[16]);

    txn(1'b1, 3'b000, 32'h41, 32'h0000_0077, 1'b0, 32'd0, 2);
    memchk(6'd16, model_mem[16]);
    txn(1'b0, 3'b010, 32'h40, 32'd0, 1'b1, model_mem[16], 0);

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/lsu.md
# lsu

Load/store unit sitting directly upstream of the word-only data memory. It accepts one byte/halfword/word load or store from the core and checks alignment. Sub-word stores become a read-modify-write sequence, because the memory only performs aligned 32-bit writes. Load data is returned extracted and sign- or zero-extended, so the core never sees raw memory words.

## Interface
- Parameters: none.
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core presents a request.
- req_ready  out  1  unit can accept; high only in IDLE.
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3: LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; the low byte or halfword is used for SB/SH.
- resp_valid  out  1  one-cycle pulse when the request completes.
- resp_rdata  out  32  extended load data; valid with resp_valid; 0 for stores and errors.
- resp_err  out  1  misaligned or illegal request; valid with resp_valid.
- mem_we  out  1  memory write enable.
- mem_addr  out  32  memory address; always word-aligned (bits [1:0] = 00).
- mem_wd  out  32  memory write data.
- mem_rd  in  32  memory read data; combinational (asynchronous read) from mem_addr.

## Operation
- States: IDLE, ACCESS, WRITE, DONE.
- **IDLE:**
  - req_ready=1.
  - On req_valid, latch store flag, funct3, address and wdata.
  - Illegal funct3 (load 011/110/111, store 1xx/011) or misaligned address: set err, go to DONE.
  - Otherwise go to ACCESS.
- **ACCESS:**
  - mem_addr = {addr[31:2], 2'b00}.
  - Load: select the byte addr[1:0] or halfword addr[1], sign-extend (LB/LH) or zero-extend (LBU/LHU), register into rdata, go to DONE.
  - SW: mem_we=1, mem_wd=wdata, go to DONE.
  - SB/SH: register the merged word (mem_rd with the selected byte/halfword lane replaced by wdata[7:0]/[15:0]), go to WRITE.
- **WRITE:** mem_we=1, mem_wd=merged word, same mem_addr, go to DONE.
- **DONE:**
  - resp_valid=1, with resp_rdata and resp_err driven from registers.
  - req_ready=0; a new request is not accepted this cycle.
  - Go to IDLE.
- mem_we is 0 in IDLE and DONE, on any error path, and whenever rst=1.
- mem_addr holds the last latched aligned address outside ACCESS/WRITE; mem_wd is 0 when mem_we=0.
- Alignment: halfword needs addr[0]=0; word needs addr[1:0]=00.

## Timing
- Reset: state=IDLE; req_ready=1; resp_valid=0; resp_rdata=0; resp_err=0; mem_we=0; mem_addr=0; mem_wd=0.
- Latency from the accept edge to resp_valid:
  - Load and SW: 2 cycles (ACCESS, DONE).
  - SB/SH: 3 cycles (ACCESS, WRITE, DONE).
  - Error: 1 cycle (DONE).
- Throughput: at most one request per 3 cycles for loads/SW; a request held on req_valid during non-IDLE states waits for IDLE.
- Reset asserted mid-operation (ACCESS or WRITE): no memory write occurs in that cycle, no resp_valid is produced, and the unit is in IDLE next cycle.
- The memory write commits on the rising edge that ends ACCESS (SW) or WRITE (SB/SH); a load issued next observes the new data.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - Misaligned halfword/word requests produce resp_err=1.
  - No memory access is made and the write is suppressed.
- LSU_MISALIGN_TRAP_EN undefined:
  - Misalignment is not checked; low address bits are forced to natural alignment (halfword clears bit 0, word clears bits [1:0]).
  - The access proceeds normally and resp_err is raised only for illegal funct3.

## Test plan
- Memory word 0x40 = 0x8765_43A1. LB @0x40 → resp_rdata=0xFFFF_FFA1. LBU @0x43 → 0x0000_0087. LH @0x42 → 0xFFFF_8765. LW @0x40 → 0x8765_43A1. Each response arrives 2 cycles after accept.
- SB wdata=0xXXXX_XX5C @0x41 on word 0x1122_3344 → mem_we pulses once in WRITE with mem_wd=0x1122_5C44 at mem_addr 0x40. resp_valid arrives 3 cycles after accept. A follow-up LW reads 0x1122_5C44.
- SH 0xBEEF @0x12 over word 0 → word becomes 0xBEEF_0000. SW 0xDEAD_BEEF @0x14 → single write in ACCESS.
- With LSU_MISALIGN_TRAP_EN: LW @0x42 → resp_err=1 and resp_rdata=0 one cycle after accept, with mem_we never asserted. Without it: the same request reads word 0x40 with resp_err=0.
- Illegal funct3 011 on a load → resp_err=1, no memory access, in both builds.
- rst asserted during the WRITE state of an SB → memory unchanged, no resp_valid, req_ready=1 on the following cycle.
